// File: rtl/fill_ctrl_b_if.sv
// Handshake bundle between the B-sequence fill controller and its user.
interface fill_ctrl_b_if #(
  parameter int cycleB0 = 26
);
  logic               Load;
  logic [cycleB0-1:0] Seed_B;
  logic               Run;
  logic               Enable;
  logic               Fill_En_B;
  logic               New_Fill_B;
  logic               Busy;
  logic               Fill_Done;
  logic [15:0]        Chip_Cnt;
  logic               Epoch;

  modport master (
    output Load, Seed_B, Run,
    input  Enable, Fill_En_B, New_Fill_B, Busy, Fill_Done, Chip_Cnt, Epoch
  );

  modport slave (
    input  Load, Seed_B, Run,
    output Enable, Fill_En_B, New_Fill_B, Busy, Fill_Done, Chip_Cnt, Epoch
  );
endinterface

// File: rtl/fill_ctrl_b.sv
// Serialises a parallel seed MSB-first into the B-sequence register, then
// gates code generation and counts chips within each code epoch.
module fill_ctrl_b #(
  parameter int cycleB0   = 26,
  parameter int EPOCH_LEN = 1023
) (
  input logic         Clock,
  input logic         Reset,
  fill_ctrl_b_if.slave bus
);
  localparam int IW = (cycleB0 > 1) ? $clog2(cycleB0) : 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t             state_q, state_d;
  logic [cycleB0-1:0] shadow_q, shadow_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               en_q, en_d;
  logic               fill_q, fill_d;
  logic               nf_q, nf_d;
  logic               done_q, done_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               epoch_q, epoch_d;

  // Every output is computed one cycle ahead and registered, so the first
  // serial bit is taken straight from Seed_B on the load edge.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    en_d     = 1'b0;
    fill_d   = 1'b0;
    nf_d     = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    epoch_d  = 1'b0;
    case (state_q)
      FILL: begin
        if (idx_q != '0) begin
          idx_d  = idx_q - 1'b1;
          en_d   = 1'b1;
          fill_d = 1'b1;
          nf_d   = shadow_q[idx_d];
        end else begin
          state_d = RUN;
          done_d  = 1'b1;
          en_d    = bus.Run;
        end
      end
      RUN: begin
        en_d = bus.Run;
        if (en_q) begin
          if (cnt_q == 16'(EPOCH_LEN - 1)) begin
            cnt_d   = '0;
            epoch_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
    // A load outside FILL overrides everything above, including Run.
    if (bus.Load && state_q != FILL) begin
      state_d  = FILL;
      shadow_d = bus.Seed_B;
      idx_d    = IW'(cycleB0 - 1);
      en_d     = 1'b1;
      fill_d   = 1'b1;
      nf_d     = bus.Seed_B[cycleB0-1];
      done_d   = 1'b0;
      cnt_d    = '0;
      epoch_d  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      en_q     <= 1'b0;
      fill_q   <= 1'b0;
      nf_q     <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      epoch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      en_q     <= en_d;
      fill_q   <= fill_d;
      nf_q     <= nf_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      epoch_q  <= epoch_d;
    end
  end

  assign bus.Enable     = en_q;
  assign bus.Fill_En_B  = fill_q;
  assign bus.Busy       = fill_q;
  assign bus.New_Fill_B = nf_q;
  assign bus.Fill_Done  = done_q;
  assign bus.Chip_Cnt   = cnt_q;
  assign bus.Epoch      = epoch_q;
endmodule

// File: tb/tb_fill_ctrl_b.sv
// Bench for fill_ctrl_b: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a fill/chip-count model.
module tb_fill_ctrl_b;
  localparam int N = 26;
  localparam int E = 5;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fill_ctrl_b_if #(.cycleB0(N)) bus ();

  fill_ctrl_b #(.cycleB0(N), .EPOCH_LEN(E)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0=idle 1=fill 2=run; fill position k counts 1..N;
  // chips is the unbounded number of enabled run cycles since the last fill.
  int         m_mode  = 0;
  int         m_k     = 0;
  logic [N-1:0] m_seed = '0;
  longint     m_chips = 0;
  bit         m_en    = 0;
  bit         m_done  = 0;
  bit         m_epoch = 0;
  bit         m_valid = 0;

  always @(posedge Clock) begin : model
    bit inc;
    inc    = 0;
    m_done = 0;
    if (Reset) begin
      m_mode  = 0;
      m_chips = 0;
      m_en    = 0;
      m_valid = 1;
    end else if (m_mode != 1 && bus.Load) begin
      m_mode  = 1;
      m_seed  = bus.Seed_B;
      m_k     = 1;
      m_chips = 0;
      m_en    = 1;
    end else if (m_mode == 1) begin
      if (m_k < N) m_k++;
      else begin
        m_mode = 2;
        m_done = 1;
        m_en   = bus.Run;
      end
    end else if (m_mode == 2) begin
      if (m_en) begin
        m_chips++;
        inc = 1;
      end
      m_en = bus.Run;
    end
    m_epoch = inc && (m_chips % E == 0);
  end

  always @(negedge Clock) begin : compare
    if (m_valid) begin
      chk("m_fill_en", 32'(bus.Fill_En_B), 32'(m_mode == 1));
      chk("m_busy", 32'(bus.Busy), 32'(m_mode == 1));
      chk("m_new_fill", 32'(bus.New_Fill_B), (m_mode == 1) ? 32'(m_seed[N-m_k]) : 32'(0));
      chk("m_enable", 32'(bus.Enable), 32'(m_en));
      chk("m_fill_done", 32'(bus.Fill_Done), 32'(m_done));
      chk("m_chip_cnt", 32'(bus.Chip_Cnt), 32'(m_chips % E));
      chk("m_epoch", 32'(bus.Epoch), 32'(m_epoch));
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_enable"}, 32'(bus.Enable), 0);
    chk({tag, "_fill_en"}, 32'(bus.Fill_En_B), 0);
    chk({tag, "_new_fill"}, 32'(bus.New_Fill_B), 0);
    chk({tag, "_busy"}, 32'(bus.Busy), 0);
    chk({tag, "_fill_done"}, 32'(bus.Fill_Done), 0);
    chk({tag, "_chip_cnt"}, 32'(bus.Chip_Cnt), 0);
    chk({tag, "_epoch"}, 32'(bus.Epoch), 0);
  endtask

  // Load seed s at this negedge; optionally pulse Load with seed s2 at fill
  // cycle (load_at+1). Checks the serial stream and the Fill_Done cycle.
  task automatic fill_check(input logic [N-1:0] s, input string tag,
                            input int load_at, input logic [N-1:0] s2);
    bus.Load   = 1'b1;
    bus.Seed_B = s;
    @(negedge Clock);
    bus.Load = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == load_at) begin
        bus.Load   = 1'b1;
        bus.Seed_B = s2;
      end else begin
        bus.Load = 1'b0;
      end
      chk({tag, "_fill_en"}, 32'(bus.Fill_En_B), 1);
      chk({tag, "_bit"}, 32'(bus.New_Fill_B), 32'(s[N-1-i]));
      chk({tag, "_cnt_in_fill"}, 32'(bus.Chip_Cnt), 0);
      @(negedge Clock);
    end
    bus.Load = 1'b0;
    chk({tag, "_done"}, 32'(bus.Fill_Done), 1);
    chk({tag, "_fill_en_off"}, 32'(bus.Fill_En_B), 0);
    chk({tag, "_cnt_run_entry"}, 32'(bus.Chip_Cnt), 0);
  endtask

  initial begin
    logic [N-1:0] alt;
    logic [3:0]   runseq;
    bit           found;
    bus.Load   = 1'b0;
    bus.Run    = 1'b0;
    bus.Seed_B = '0;

    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check_idle("reset");

    // Alternating seed: literal 1,0,1,0,... stream and exactly one Fill_Done.
    alt = 26'h2AAAAAA;
    bus.Load   = 1'b1;
    bus.Seed_B = alt;
    @(negedge Clock);
    bus.Load = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("alt_fill_en", 32'(bus.Fill_En_B), 1);
      chk("alt_busy", 32'(bus.Busy), 1);
      chk("alt_bit", 32'(bus.New_Fill_B), 32'(i % 2 == 0));
      @(negedge Clock);
    end
    chk("alt_done", 32'(bus.Fill_Done), 1);
    chk("alt_busy_off", 32'(bus.Busy), 0);
    @(negedge Clock);
    chk("alt_done_once", 32'(bus.Fill_Done), 0);

    // Run held high with EPOCH_LEN=5: count 0..4 wraps, Epoch on the wrap.
    bus.Run = 1'b1;
    fill_check(N'($urandom), "epoch_fill", -1, '0);
    for (int j = 0; j < 11; j++) begin
      chk("ep_cnt", 32'(bus.Chip_Cnt), 32'(j % 5));
      chk("ep_epoch", 32'(bus.Epoch), 32'(j > 0 && j % 5 == 0));
      chk("ep_enable", 32'(bus.Enable), 1);
      @(negedge Clock);
    end

    // Run 1,0,0,1: Enable lags by one cycle, no Epoch while paused.
    runseq = 4'b1001;
    for (int i = 3; i >= 0; i--) begin
      bus.Run = runseq[i];
      @(negedge Clock);
      chk("pause_enable", 32'(bus.Enable), 32'(runseq[i]));
      if (!runseq[i]) chk("pause_epoch", 32'(bus.Epoch), 0);
    end

    // Load during fill with a different seed is ignored.
    fill_check(26'h1234567, "ignore_load", 9, 26'h2FEDCBA);

    // Reload from RUN at Chip_Cnt=3 with seed 1.
    bus.Run = 1'b1;
    found = 0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge Clock);
      if (bus.Chip_Cnt == 16'd3) found = 1;
    end
    chk("wait_cnt3", 32'(found), 1);
    fill_check(26'h0000001, "reload", -1, '0);

    // Reset at fill cycle 12 aborts with no Fill_Done.
    bus.Run    = 1'b0;
    bus.Load   = 1'b1;
    bus.Seed_B = N'($urandom);
    @(negedge Clock);
    bus.Load = 1'b0;
    repeat (11) @(negedge Clock);
    chk("abort_mid_fill", 32'(bus.Fill_En_B), 1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check_idle("abort");
    for (int i = 0; i < N + 4; i++) begin
      @(negedge Clock);
      chk("abort_no_done", 32'(bus.Fill_Done), 0);
      chk("abort_idle", 32'(bus.Fill_En_B), 0);
    end
    fill_check(N'($urandom), "after_abort", -1, '0);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      Reset      = ($urandom % 400 == 0);
      bus.Load   = ($urandom % 30 == 0);
      bus.Run    = ($urandom % 4 != 0);
      bus.Seed_B = N'($urandom);
    end
    Reset    = 1'b0;
    bus.Load = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fill_ctrl_b.md
FILL_CTRL_B -- requirements
Module: fill_ctrl_b

Interface
REQ-001 Parameter cycleB0, default 26, SHALL set the seed length in bits and the number of fill cycles.
REQ-002 Parameter EPOCH_LEN, default 1023, SHALL set the chip count per code epoch (legal range 2..65535).
REQ-003 Port Clock, input, 1, SHALL be the single clock; all state updates on posedge Clock.
REQ-004 Port Reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port Load, input, 1, SHALL request a new seed fill when high.
REQ-006 Port Seed_B, input, cycleB0, SHALL carry the parallel seed to serialize.
REQ-007 Port Run, input, 1, SHALL request code generation (shift) cycles after the fill.
REQ-008 Port Enable, output, 1, SHALL be the shift enable driven to the B-sequence register.
REQ-009 Port Fill_En_B, output, 1, SHALL select serial fill data at the B-sequence register input.
REQ-010 Port New_Fill_B, output, 1, SHALL carry the current serial seed bit.
REQ-011 Port Busy, output, 1, SHALL be high while in FILL.
REQ-012 Port Fill_Done, output, 1, SHALL pulse for one cycle on completion of a fill.
REQ-013 Port Chip_Cnt, output, 16, SHALL give the chip index within the current epoch.
REQ-014 Port Epoch, output, 1, SHALL pulse for one cycle at each epoch wrap.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 FSM states SHALL be IDLE, FILL, RUN.
REQ-017 IDLE: Enable=0, Fill_En_B=0, New_Fill_B=0; Load=1 -> capture Seed_B into shadow register, bit index = cycleB0-1, go to FILL.
REQ-018 FILL: Enable=1, Fill_En_B=1, Busy=1, New_Fill_B = shadow[bit index], MSB first, index decrementing once per cycle.
REQ-019 FILL SHALL last exactly cycleB0 cycles so that after the last shift seed bit k sits at stage k of the B-sequence register.
REQ-020 Load sampled high at edge t -> Fill_En_B=1 on cycles t+1..t+cycleB0, New_Fill_B=Seed_B[cycleB0-1] on cycle t+1 and Seed_B[0] on cycle t+cycleB0.
REQ-021 At the end of the fill cycle with index 0: state goes to RUN; Fill_Done=1 for the first RUN cycle only.
REQ-022 Load high during FILL SHALL be ignored; Seed_B changes during FILL SHALL NOT affect the fill in progress.
REQ-023 RUN: Fill_En_B=0, New_Fill_B=0, Enable = Run as registered on the previous edge.
REQ-024 Load high in RUN SHALL re-enter FILL with a fresh seed capture, with timing identical to REQ-020; Load takes priority over Run.
REQ-025 Chip_Cnt SHALL clear to 0 on entry to FILL, and SHALL increment by 1 after each RUN cycle in which Enable=1.
REQ-026 At Chip_Cnt = EPOCH_LEN-1 with Enable=1: Chip_Cnt wraps to 0 and Epoch=1 for that one cycle.
REQ-027 Chip_Cnt and Epoch SHALL hold (Epoch=0) in any RUN cycle with Enable=0.
REQ-028 No return from RUN to IDLE except by Reset.

Reset
REQ-029 Reset=1 at an edge SHALL force IDLE: all outputs 0, shadow register 0, bit index 0, Chip_Cnt 0; Reset takes priority over Load.
REQ-030 Reset mid-FILL SHALL abort the fill: Fill_En_B and Enable go 0 on the next cycle, and no Fill_Done is issued.

Verification
REQ-031 Reset, then Load=1 for 1 cycle with Seed_B=26'h2AAAAAA -> Fill_En_B high 26 cycles; New_Fill_B = 1,0,1,0,... (26 bits); Busy matches; one Fill_Done pulse after.
REQ-032 Fill with Run held 1, EPOCH_LEN=5 -> Chip_Cnt 0,1,2,3,4,0; Epoch=1 only on the 4->0 wrap; repeats every 5 cycles.
REQ-033 Run toggled 1,0,0,1 in RUN -> Enable follows with 1-cycle lag; Chip_Cnt holds during Enable=0; no Epoch while paused.
REQ-034 Load pulsed at fill cycle 10 with a different Seed_B -> ignored; serial stream still matches the original seed; fill still 26 cycles.
REQ-035 Load in RUN at Chip_Cnt=3, Seed_B=26'h0000001 -> 25 zeros then a 1; Chip_Cnt=0 at RUN re-entry.
REQ-036 Reset asserted at fill cycle 12 -> next cycle all outputs 0 and state IDLE; no Fill_Done; a new Load starts a full 26-cycle fill.
